// File: rtl/fpu_cmp_pipe.sv
// fpu_cmp_pipe: 2-stage pipelined floating-point compare / min / max unit
// with valid/ready backpressure and a pass-through tag.
// Optional feature macro: FPU_CMP_NAN_EN (NaN detection, UNORDERED result).
module fpu_cmp_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res,
  output logic [1:0]       out_code,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {CODE_EQ, CODE_LT, CODE_GT, CODE_UN} code_e;
  typedef enum logic [1:0] {OP_CMP, OP_MIN, OP_MAX, OP_RSV} op_e;

  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = rst_n && s1_adv;
  assign out_valid = s2_valid;

  // Stage-1 magnitude relation on the raw {exp,man} fields
  logic [W-2:0] mag_a, mag_b;
  assign mag_a = in_a[W-2:0];
  assign mag_b = in_b[W-2:0];

  logic [W-1:0]     s1_a, s1_b;
  op_e              s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_mag_lt, s1_mag_eq, s1_za, s1_zb;
`ifdef FPU_CMP_NAN_EN
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  logic s1_nan_a, s1_nan_b;
`endif

  // Stage 1: capture operands and precompute magnitude/zero/NaN flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a      <= in_a;
        s1_b      <= in_b;
        s1_op     <= op_e'(in_op);
        s1_tag    <= in_tag;
        s1_mag_lt <= mag_a < mag_b;
        s1_mag_eq <= mag_a == mag_b;
        s1_za     <= mag_a == '0;
        s1_zb     <= mag_b == '0;
`ifdef FPU_CMP_NAN_EN
        s1_nan_a  <= (in_a[W-2:MAN_W] == '1) && (in_a[MAN_W-1:0] != '0);
        s1_nan_b  <= (in_b[W-2:MAN_W] == '1) && (in_b[MAN_W-1:0] != '0);
`endif
      end
    end
  end

  code_e        code;
  logic [W-1:0] res;
  logic         sa, sb, zero_pair;
  assign sa        = s1_a[W-1];
  assign sb        = s1_b[W-1];
  assign zero_pair = s1_za && s1_zb;

  // Stage-2 combinational: resolve sign/mode into code and selected result
  always_comb begin
    code = CODE_EQ;
    if (zero_pair)      code = CODE_EQ;
    else if (sa != sb)  code = sa ? CODE_LT : CODE_GT;
    else if (s1_mag_eq) code = CODE_EQ;
    else if (!sa)       code = s1_mag_lt ? CODE_LT : CODE_GT;
    else                code = s1_mag_lt ? CODE_GT : CODE_LT;
`ifdef FPU_CMP_NAN_EN
    if (s1_nan_a || s1_nan_b) code = CODE_UN;
`endif

    res = '0;
    case (s1_op)
      OP_MIN: begin
        res = (code == CODE_GT) ? s1_b : s1_a;
        if (zero_pair && (sa != sb)) res = sa ? s1_a : s1_b;
      end
      OP_MAX: begin
        res = (code == CODE_LT) ? s1_b : s1_a;
        if (zero_pair && (sa != sb)) res = sa ? s1_b : s1_a;
      end
      default: res[1:0] = code;
    endcase
`ifdef FPU_CMP_NAN_EN
    if (s1_op == OP_MIN || s1_op == OP_MAX) begin
      if (s1_nan_a && s1_nan_b) res = QNAN;
      else if (s1_nan_a)        res = s1_b;
      else if (s1_nan_b)        res = s1_a;
    end
`endif
  end

  // Stage 2: registered outputs, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_res  <= '0;
      out_code <= '0;
      out_tag  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_res  <= res;
        out_code <= code;
        out_tag  <= s1_tag;
      end
    end
  end

endmodule
